// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS
// 7-segment digits sharing one BCD-to-7-segment decoder.
// A new value is double-buffered through a shadow register and only
// committed to the displayed (active) register at a frame boundary.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value_bcd,
  output logic [3:0]              dec_bcd,
  output logic                    dec_blank,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_tick
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int MAX_CYC = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    tick_q, tick_d;

  logic                    accept;
  logic                    commit;
  logic [3:0]              cur_digit;
  logic                    lead_blank;

  assign accept = load_valid & ~pending_q;

  // Next-state logic: handshake capture, scan sequencing and frame-boundary commit
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    tick_d    = 1'b0;
    commit    = 1'b0;

    if (accept) begin
      pending_d = 1'b1;
      shadow_d  = value_bcd;
    end

    case (state_q)
      ST_OFF: begin
        if (pending_q) begin
          commit  = 1'b1;
          state_d = ST_SHOW;
          idx_d   = '0;
          cnt_d   = SHOW_LOAD;
        end
      end
      ST_SHOW: begin
        if (cnt_q == '0) begin
          state_d = ST_GUARD;
          cnt_d   = GUARD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) begin
          state_d = ST_SHOW;
          cnt_d   = SHOW_LOAD;
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            tick_d = 1'b1;
            commit = pending_q;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase

    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously so a pending value is discarded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      tick_q    <= tick_d;
    end
  end

  // Select the active digit addressed by the scan index
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = active_q[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic above_zero;

  // Blank digit idx>0 when it and every higher digit are zero; digit 0 always shows
  always_comb begin
    lead_blank = 1'b0;
    above_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      above_zero = above_zero & (active_q[4*i +: 4] == 4'd0);
      if ((idx_q == IDX_W'(i)) && above_zero) lead_blank = 1'b1;
    end
  end
`else
  assign lead_blank = 1'b0;
`endif

  // Output decode: only SHOW drives a digit; OFF and GUARD keep everything dark
  always_comb begin
    digit_sel = '1;
    dec_bcd   = 4'd0;
    dec_blank = 1'b1;
    if (state_q == ST_SHOW) begin
      dec_bcd   = cur_digit;
      dec_blank = (cur_digit > 4'd9) | lead_blank;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) digit_sel[i] = 1'b0;
      end
    end
  end

  assign load_ready = ~pending_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed, table-driven bench for display_scan_ctrl
// with NUM_DIGITS=4, SCAN_DIV=4, GUARD_CYC=1 (frame = 20 cycles).
// Expectations follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int GC = 1;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [3:0] SO = 4'b1111;
  localparam logic [3:0] S0 = 4'b1110;
  localparam logic [3:0] S1 = 4'b1101;
  localparam logic [3:0] S2 = 4'b1011;
  localparam logic [3:0] S3 = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] value_bcd = 16'h0;
  logic        load_ready;
  logic [3:0]  dec_bcd;
  logic        dec_blank;
  logic [3:0]  digit_sel;
  logic        frame_tick;

  int errorCount = 0;
  int checkCount = 0;

  typedef struct {
    bit          rstN;
    bit          lv;
    logic [15:0] val;
    int          cycles;
    logic [3:0]  sel;
    logic [3:0]  bcd;
    bit          blank;
    bit          ready;
    bit          tick;
  } vecT;

  vecT vecs[$];

  display_scan_ctrl #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD),
    .GUARD_CYC (GC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .value_bcd (value_bcd),
    .dec_bcd   (dec_bcd),
    .dec_blank (dec_blank),
    .digit_sel (digit_sel),
    .frame_tick(frame_tick)
  );

  // Free-running 100 MHz-style clock
  always #5 clk = ~clk;

  // Hard stop in case the design never lets the bench finish
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void addVec(input bit rstN, input bit lv, input logic [15:0] val,
                                 input int cycles, input logic [3:0] sel, input logic [3:0] bcd,
                                 input bit blank, input bit ready, input bit tick);
    vecT v;
    v.rstN = rstN; v.lv = lv; v.val = val; v.cycles = cycles;
    v.sel = sel; v.bcd = bcd; v.blank = blank; v.ready = ready; v.tick = tick;
    vecs.push_back(v);
  endfunction

  function automatic void addGuard(input bit ready);
    addVec(1'b1, 1'b0, 16'h0, 1, SO, 4'd0, 1'b1, ready, 1'b0);
  endfunction

  task automatic checkVal(input string what, input logic [3:0] actual, input logic [3:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", what, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vecT v);
    rst_n      = v.rstN;
    load_valid = v.lv;
    value_bcd  = v.val;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] sel, input logic [3:0] bcd,
                             input bit blank, input bit ready, input bit tick);
    checkVal({tag, " digit_sel"}, digit_sel, sel);
    checkVal({tag, " dec_bcd"}, dec_bcd, bcd);
    checkVal({tag, " dec_blank"}, 4'(dec_blank), 4'(blank));
    checkVal({tag, " load_ready"}, 4'(load_ready), 4'(ready));
    checkVal({tag, " frame_tick"}, 4'(frame_tick), 4'(tick));
  endtask

  initial begin
    bit found;

    // Reset values while rst_n is held low
    #12;
    checkOutput("reset", SO, 4'd0, 1'b1, 1'b1, 1'b0);

    // Load 0x1234 and follow one full frame
    addVec(1, 1, 16'h1234, 1, SO, 4'd0, 1, 0, 0);
    addVec(1, 0, 16'h0, 4, S0, 4'd4, 0, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S1, 4'd3, 0, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S2, 4'd2, 0, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S3, 4'd1, 0, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 1, S0, 4'd4, 0, 1, 1);
    addVec(1, 0, 16'h0, 3, S0, 4'd4, 0, 1, 0);
    addGuard(1);
    // Mid-frame load of 0x5678, then a second offer (0x9999) while pending
    addVec(1, 1, 16'h5678, 1, S1, 4'd3, 0, 0, 0);
    addVec(1, 1, 16'h9999, 3, S1, 4'd3, 0, 0, 0);
    addVec(1, 1, 16'h9999, 1, SO, 4'd0, 1, 0, 0);
    addVec(1, 1, 16'h9999, 4, S2, 4'd2, 0, 0, 0);
    addVec(1, 1, 16'h9999, 1, SO, 4'd0, 1, 0, 0);
    addVec(1, 1, 16'h9999, 4, S3, 4'd1, 0, 0, 0);
    addVec(1, 1, 16'h9999, 1, SO, 4'd0, 1, 0, 0);
    addVec(1, 0, 16'h0, 1, S0, 4'd8, 0, 1, 1);
    addVec(1, 0, 16'h0, 3, S0, 4'd8, 0, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S1, 4'd7, 0, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S2, 4'd6, 0, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S3, 4'd5, 0, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 1, S0, 4'd8, 0, 1, 1);

    // 0x00A7: invalid digit blanked, leading zeros depend on the build
    addVec(0, 0, 16'h0, 2, SO, 4'd0, 1, 1, 0);
    addVec(1, 1, 16'h00A7, 1, SO, 4'd0, 1, 0, 0);
    addVec(1, 0, 16'h0, 4, S0, 4'd7, 0, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S1, 4'hA, 1, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S2, 4'd0, LZB, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S3, 4'd0, LZB, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 1, S0, 4'd7, 0, 1, 1);

    // 0x0000: digit 0 always visible
    addVec(0, 0, 16'h0, 2, SO, 4'd0, 1, 1, 0);
    addVec(1, 1, 16'h0000, 1, SO, 4'd0, 1, 0, 0);
    addVec(1, 0, 16'h0, 4, S0, 4'd0, 0, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S1, 4'd0, LZB, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S2, 4'd0, LZB, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 4, S3, 4'd0, LZB, 1, 0);
    addGuard(1);
    addVec(1, 0, 16'h0, 1, S0, 4'd0, 0, 1, 1);

    for (int r = 0; r < vecs.size(); r++) begin
      for (int c = 0; c < vecs[r].cycles; c++) begin
        applyStimulus(vecs[r]);
        @(posedge clk);
        #1;
        checkOutput($sformatf("row%0d.%0d", r, c), vecs[r].sel, vecs[r].bcd,
                    vecs[r].blank, vecs[r].ready, vecs[r].tick);
      end
    end

    // Asynchronous reset during SHOW of digit 2 with a value pending
    load_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_valid = 1'b1;
    value_bcd = 16'h1234;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (digit_sel == S2) begin
        found = 1'b1;
        break;
      end
    end
    checkVal("reachDigit2", 4'(found), 4'd1);
    load_valid = 1'b1;
    value_bcd = 16'h5678;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    checkVal("pendingBeforeReset load_ready", 4'(load_ready), 4'd0);
    checkVal("pendingBeforeReset digit_sel", digit_sel, S2);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset", SO, 4'd0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      checkVal($sformatf("staysOff%0d digit_sel", n), digit_sel, SO);
      checkVal($sformatf("staysOff%0d frame_tick", n), 4'(frame_tick), 4'd0);
    end
    load_valid = 1'b1;
    value_bcd = 16'h0042;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("loadAfterReset", S0, 4'd2, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed 7-segment digits (range 2..8).
REQ-003 Parameter SCAN_DIV, default 50000, SHALL set the clk cycles each digit is driven (minimum 2).
REQ-004 Parameter GUARD_CYC, default 500, SHALL set the all-digits-off anti-ghost cycles between digits (minimum 1).
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port load_valid, input, 1 bit: a new display value is offered.
REQ-008 Port load_ready, output, 1 bit: the block can accept a value.
REQ-009 Port value_bcd, input, 4*NUM_DIGITS bits: packed BCD, digit 0 in bits [3:0].
REQ-010 Port dec_bcd, output, 4 bits: digit code sent to the shared BCD-to-7-segment decoder.
REQ-011 Port dec_blank, output, 1 bit: when high, the downstream segment drive is forced off.
REQ-012 Port digit_sel, output, NUM_DIGITS bits: active-low one-hot digit enable.
REQ-013 Port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-014 A transfer SHALL occur on a rising edge with load_valid=1 and load_ready=1; value_bcd is captured into a shadow register and a pending flag is set.
REQ-015 load_ready SHALL equal NOT pending; while pending=1, load_valid is ignored and value_bcd needs no stability.
REQ-016 The FSM SHALL have exactly three states:
- OFF: digit_sel all ones, dec_blank=1.
- SHOW: digit_sel[idx]=0, others 1.
- GUARD: digit_sel all ones, dec_blank=1.
REQ-017 In OFF, when pending=1, the next edge SHALL commit shadow to the active register, clear pending, set idx=0 and enter SHOW, so digit_sel[0]=0 after the edge following the accepting edge.
REQ-018 SHOW SHALL last exactly SCAN_DIV cycles and then enter GUARD.
REQ-019 GUARD SHALL last exactly GUARD_CYC cycles and then enter SHOW with idx+1, wrapping from NUM_DIGITS-1 to 0.
REQ-020 On the GUARD-to-SHOW transition that wraps idx to 0, the block SHALL pulse frame_tick for one cycle and, if pending=1, commit shadow to active and clear pending on that same edge; a mid-frame commit SHALL never occur.
REQ-021 The frame period SHALL be NUM_DIGITS*(SCAN_DIV+GUARD_CYC) cycles.
REQ-022 In SHOW, dec_bcd SHALL equal active digit idx, decoded combinationally from registered state with no extra latency.
REQ-023 In SHOW, dec_blank SHALL be 1 if the active digit is above 9 (invalid BCD) and 0 otherwise, subject to REQ-028.
REQ-024 In OFF and GUARD, dec_bcd SHALL be 0.
REQ-025 A single shared prescaler counter SHALL time both SHOW and GUARD; it reloads on every state change and never runs in OFF.

Reset
REQ-026 On rst_n=0, asynchronously and independent of clk:
- state=OFF, idx=0, pending=0, shadow=0, active=0, prescaler=0.
- Outputs: load_ready=1, digit_sel all ones, dec_blank=1, dec_bcd=0, frame_tick=0.
REQ-027 Reset asserted mid-SHOW or with pending=1 SHALL discard the pending value; after release the display stays OFF until a new transfer.

Configuration
REQ-028 With macro LEADING_ZERO_BLANK_EN defined, a digit idx>0 whose active value and all higher-index active values are 0 SHALL have dec_blank=1 in SHOW; digit 0 is never leading-blanked.
REQ-029 Without LEADING_ZERO_BLANK_EN, zero digits SHALL display normally (dec_blank=0).

Verification (NUM_DIGITS=4, SCAN_DIV=4, GUARD_CYC=1)
REQ-030 Bench: reset, then load 0x1234 -> load_ready low 1 cycle; digit_sel=1110 with dec_bcd=4 for 4 cycles, then 1111 for 1 cycle, then 1101 with dec_bcd=3; frame_tick every 20 cycles.
REQ-031 Bench: load 0x5678 mid-frame while 0x1234 is shown -> load_ready stays 0 until the wrap; the new digits appear only from digit 0 of the next frame; a second load_valid while pending is not accepted.
REQ-032 Bench: load 0x00A7 -> digit 1 (value 0xA) dec_blank=1; with LEADING_ZERO_BLANK_EN defined, digits 2 and 3 are blanked; without it, digits 2 and 3 show 0 unblanked.
REQ-033 Bench: load 0x0000 with LEADING_ZERO_BLANK_EN defined -> only digit 0 is unblanked, showing 0.
REQ-034 Bench: assert rst_n=0 mid-SHOW of digit 2 with pending=1 -> immediately digit_sel=1111, dec_blank=1, load_ready=1; after release, the block stays OFF with no frame_tick until the next load.
